// File: rtl/uart_rx.sv
// 8N1 / 8E1 / 8O1 UART receiver with 2-flop input synchronizer, mid-bit sampling
// and per-frame parity/framing error flags qualified by a one-cycle valid strobe.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  input  logic [1:0] parity_type,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_error,
  output logic       framing_error,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       shift_reg;
  logic [1:0]       par_mode;
  logic             perr;
  logic             rx_meta;
  logic             rx_s;

  // NOTE: synchronizer resets to the idle-high level so reset release never
  // looks like a falling start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
    end
  end

  // NOTE: all state updates use non-blocking assignments so every branch sees
  // the pre-edge values of cnt, idx and shift_reg.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      idx           <= '0;
      shift_reg     <= '0;
      par_mode      <= '0;
      perr          <= 1'b0;
      data_out      <= '0;
      data_valid    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      busy          <= 1'b0;
    end else begin
      data_valid    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state    <= DATA;
              par_mode <= parity_type;
              idx      <= '0;
              perr     <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == FULL_LAST) begin
            cnt            <= '0;
            shift_reg[idx] <= rx_s;
            if (idx == 3'd7) begin
              state <= (par_mode == 2'b01 || par_mode == 2'b10) ? PARITY : STOP;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PARITY: begin
          if (cnt == FULL_LAST) begin
            cnt   <= '0;
            perr  <= rx_s != ((par_mode == 2'b01) ? ^shift_reg : ~^shift_reg);
            state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == FULL_LAST) begin
            cnt           <= '0;
            data_out      <= shift_reg;
            data_valid    <= 1'b1;
            parity_error  <= perr;
            framing_error <= ~rx_s;
            // Leave at mid-stop so a following start edge is never missed.
            state         <= rx_s ? IDLE : WAIT_HIGH;
            busy          <= ~rx_s;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial UART receiver: the receive-side counterpart of the team's UART transmitter and parity generator. It samples an asynchronous `rx_in` line and recovers 8N1 or 8E1/8O1 frames (LSB first), using the same `parity_type` encoding as the transmit parity block. Each frame is delivered as a byte with a one-cycle valid strobe, qualified by parity and framing error flags. It sits between the external RX pin and the byte-consuming logic.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per bit period; must be an even number ≥ 4.
- `clk  in  1`: single clock; all logic on the rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `rx_in  in  1`: asynchronous serial line; idle high.
- `parity_type  in  2`: parity mode.
  - 00: no parity.
  - 01: even; parity bit = ^data.
  - 10: odd; parity bit = ~^data.
  - 11: no parity.
- `data_out  out  8`: last received byte; held until the next frame completes.
- `data_valid  out  1`: one-cycle pulse per completed frame.
- `parity_error  out  1`: qualifies `data_valid`; 1 = received parity bit mismatched.
- `framing_error  out  1`: qualifies `data_valid`; 1 = stop bit sampled low.
- `busy  out  1`: high in any state other than IDLE.

## Operation
- `rx_in` passes through a 2-flop synchronizer, giving `rx_s`. All decisions use `rx_s`.
- **States:**
  - **IDLE**
    - `rx_s == 0` → START, with the counter cleared.
  - **START**
    - Count `CLKS_PER_BIT/2` cycles, then sample.
    - `rx_s == 1` → IDLE (glitch rejected, no strobe).
    - `rx_s == 0` → DATA: latch `parity_type` into `par_mode`, clear bit index.
  - **DATA**
    - Every `CLKS_PER_BIT` cycles, sample `rx_s` into shift register bit `idx` (LSB first).
    - After bit 7: go to PARITY if `par_mode` ∈ {01, 10}; otherwise go to STOP.
  - **PARITY**
    - After `CLKS_PER_BIT` cycles, sample the parity bit.
    - `perr` = sampled bit ≠ expected bit, where expected is computed from the shift register per `par_mode`.
    - → STOP.
  - **STOP**
    - After `CLKS_PER_BIT` cycles, sample the stop bit.
    - Next cycle:
      - load `data_out`;
      - pulse `data_valid`;
      - drive `parity_error = perr` (0 in no-parity modes);
      - drive `framing_error = ~stop_sample`.
    - Stop sampled 1 → IDLE.
    - Stop sampled 0 → WAIT_HIGH.
  - **WAIT_HIGH**
    - Stay until `rx_s == 1`, then → IDLE.
    - Prevents a break or stuck-low line from being decoded as back-to-back frames.
- A `parity_type` change mid-frame has no effect on the current frame; it applies from the next validated start bit.
- A frame is always delivered, even on error; `data_out` is loaded with the received data bits regardless of errors.

## Timing
- Let t0 be the first cycle IDLE sees `rx_s == 0`. `rx_s` lags `rx_in` by 2 cycles.
- Sample instants, with H = `CLKS_PER_BIT/2` and N = `CLKS_PER_BIT`:
  - start bit: t0+H;
  - data bit i: t0+H+(i+1)·N;
  - parity bit: t0+H+9·N;
  - stop bit: t0+H+9·N without parity, or t0+H+10·N with parity.
- `data_valid`, `parity_error`, `framing_error` and the new `data_out` all appear the cycle after the stop sample.
  - The three flags are high for exactly one cycle.
  - `parity_error`/`framing_error` are 0 whenever `data_valid` is 0.
- Return to IDLE happens at mid-stop (not end of stop), so a start edge arriving ≥ H cycles later is caught. Back-to-back frames at full rate decode with no loss.
- `busy` rises the cycle after t0 and falls when IDLE is re-entered.
- **Reset:**
  - Forces IDLE; clears counter, index, shift register and synchronizer flops (to 1).
  - `data_out` = 0x00; `data_valid`, `parity_error`, `framing_error`, `busy` = 0.
  - Reset mid-frame discards the frame with no strobe.
  - After reset release, a start bit needs `rx_s` to go low again.

## Test plan
All scenarios use `CLKS_PER_BIT` = 16 and drive `rx_in` with 16-clock bit periods.
1. `parity_type` = 00, frame 0xA5, stop = 1 → exactly one `data_valid` pulse, t0+8+144+1 cycles after t0. `data_out` = 0xA5, both errors 0, `busy` back to 0. Repeat with `parity_type` = 11: identical result.
2. `parity_type` = 01 (even):
   - 0x0F with parity bit 0 → `data_out` = 0x0F, `parity_error` = 0.
   - Same byte with parity bit 1 → `data_out` = 0x0F, `parity_error` = 1, `framing_error` = 0.
3. `parity_type` = 10 (odd):
   - 0x0D with parity bit 0 → `parity_error` = 0.
   - 0x0D with parity bit 1 → `parity_error` = 1.
   - Also: switch `parity_type` from 10 to 00 during data bit 3 of a frame → that frame is still checked as odd (parity bit expected).
4. `rx_in` low for 5 clocks, then high → no `data_valid`; `busy` returns to 0 within 10 cycles.
5. Framing error:
   - 0x55 with stop = 0, line then held low 64 clocks → one pulse with `data_valid` = 1, `framing_error` = 1, `data_out` = 0x55; no further strobes while the line is low.
   - Line then goes high and frame 0x3C is sent → `data_out` = 0x3C, errors 0.
   - Back-to-back: frames 0x01 and 0xFE with no idle gap → two strobes, 160 cycles apart, both correct.
6. Assert `rst` for 1 cycle during data bit 4 of frame 0x77 → all outputs 0 the next cycle, no strobe for 0x77. The following frame 0x81 decodes correctly.
